// File: rtl/spi_tx_arbiter_if.sv
// Byte-transmit bus between two requesters, the arbiter and one SPI master.
// slave: arbiter side. master: requester / SPI-master side (testbench or glue).
interface spi_tx_arbiter_if;
  logic [1:0] i_Req_Valid;
  logic [7:0] i_Req_Byte0;
  logic [7:0] i_Req_Byte1;
  logic [1:0] i_Req_Last;
  logic [1:0] o_Req_Ack;
  logic [1:0] o_Grant;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready;
  logic       o_Busy;

  modport slave (
    input  i_Req_Valid, i_Req_Byte0, i_Req_Byte1, i_Req_Last, i_TX_Ready,
    output o_Req_Ack, o_Grant, o_TX_Byte, o_TX_DV, o_Busy
  );

  modport master (
    output i_Req_Valid, i_Req_Byte0, i_Req_Byte1, i_Req_Last, i_TX_Ready,
    input  o_Req_Ack, o_Grant, o_TX_Byte, o_TX_DV, o_Busy
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Two-requester burst arbiter in front of a single-CS SPI byte transmitter.
// Bursts are never interleaved; a programmable idle gap follows each burst
// so the slave sees CS deassert and settle.
//
// state | meaning
// IDLE  | no owner; waiting for SPI ready and any valid request
// ISSUE | DV and ack pulse for one cycle; SPI ready not yet meaningful
// BUSY  | owner holds grant; waiting for SPI ready (next byte or burst end)
// GAP   | burst finished; counting idle clocks, requests ignored
module spi_tx_arbiter #(
  parameter int GAP_CYCLES = 100
) (
  input logic            i_Clk,
  input logic            i_Rst_L,
  spi_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_GAP} state_t;

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ack_q, ack_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dv_q, tx_dv_d;
  logic             last_q, last_d;
  logic             rr_q, rr_d;       // index of requester favoured on a tie
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             busy_q, busy_d;

  logic             do_issue;
  logic             win;

  // Next-state, byte issue and gap counting.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = 2'b00;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    last_d    = last_q;
    rr_d      = rr_q;
    gap_d     = gap_q;
    do_issue  = 1'b0;
    win       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_TX_Ready && (bus.i_Req_Valid != 2'b00)) begin
          do_issue = 1'b1;
          win      = (bus.i_Req_Valid == 2'b11) ? rr_q : bus.i_Req_Valid[1];
        end
      end
      S_ISSUE: begin
        // SPI master drops ready one cycle after DV, so it is not sampled here.
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (bus.i_TX_Ready) begin
          if (last_q) begin
            grant_d = 2'b00;
            rr_d    = ~grant_q[1];
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          end else if (bus.i_Req_Valid[grant_q[1]]) begin
            do_issue = 1'b1;
            win      = grant_q[1];
          end
        end
      end
      S_GAP: begin
        if (gap_q <= CNT_W'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_issue) begin
      tx_byte_d = win ? bus.i_Req_Byte1 : bus.i_Req_Byte0;
      tx_dv_d   = 1'b1;
      ack_d     = win ? 2'b10 : 2'b01;
      grant_d   = win ? 2'b10 : 2'b01;
      last_d    = bus.i_Req_Last[win];
      state_d   = S_ISSUE;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      ack_q     <= 2'b00;
      tx_byte_q <= 8'h00;
      tx_dv_q   <= 1'b0;
      last_q    <= 1'b0;
      rr_q      <= 1'b0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
      last_q    <= last_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_Req_Ack = ack_q;
  assign bus.o_Grant   = grant_q;
  assign bus.o_TX_Byte = tx_byte_q;
  assign bus.o_TX_DV   = tx_dv_q;
  assign bus.o_Busy    = busy_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: one instance with a 4-cycle gap, one with no gap.
// Expected bytes are queued when stimulus starts; monitors pop on each DV.
module tb_spi_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_tx_arbiter_if if4 ();
  spi_tx_arbiter_if if0 ();

  spi_tx_arbiter #(.GAP_CYCLES(4)) dut4 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if4.slave));
  spi_tx_arbiter #(.GAP_CYCLES(0)) dut0 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if0.slave));

  // requester drive for the gap-4 instance (a_*) and the no-gap instance (z_*)
  logic       a_v0 = 1'b0, a_v1 = 1'b0, a_l0 = 1'b0, a_l1 = 1'b0;
  logic [7:0] a_b0 = 8'h00, a_b1 = 8'h00;
  logic       z_v1 = 1'b0, z_l1 = 1'b0;
  logic [7:0] z_b1 = 8'h00;
  logic       hold4 = 1'b0;

  assign if4.i_Req_Valid = {a_v1, a_v0};
  assign if4.i_Req_Byte0 = a_b0;
  assign if4.i_Req_Byte1 = a_b1;
  assign if4.i_Req_Last  = {a_l1, a_l0};
  assign if0.i_Req_Valid = {z_v1, 1'b0};
  assign if0.i_Req_Byte0 = 8'h00;
  assign if0.i_Req_Byte1 = z_b1;
  assign if0.i_Req_Last  = {z_l1, 1'b0};

  // SPI master models: ready drops after DV and returns N cycles later
  logic rdy4_q, rdy0_q;
  int   cnt4, cnt0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy4_q <= 1'b1; cnt4 <= 0;
    end else if (if4.o_TX_DV) begin
      rdy4_q <= 1'b0; cnt4 <= 16;
    end else if (cnt4 > 0) begin
      cnt4 <= cnt4 - 1;
      if (cnt4 == 1) rdy4_q <= 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy0_q <= 1'b1; cnt0 <= 0;
    end else if (if0.o_TX_DV) begin
      rdy0_q <= 1'b0; cnt0 <= 3;
    end else if (cnt0 > 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) rdy0_q <= 1'b1;
    end
  end

  assign if4.i_TX_Ready = rdy4_q & ~hold4;
  assign if0.i_TX_Ready = rdy0_q;

  typedef struct packed {logic [7:0] b; logic r;} exp_t;
  exp_t q4[$];
  exp_t q0[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic exp_t mk(input logic [7:0] b, input logic r);
    exp_t e;
    e.b = b;
    e.r = r;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && if4.o_TX_DV) begin
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut4 unexpected DV: got byte 0x%0h expected none", if4.o_TX_Byte);
      end else begin
        e = q4.pop_front();
        check("dut4 byte", if4.o_TX_Byte, e.b);
        check("dut4 grant", if4.o_Grant, e.r ? 2'b10 : 2'b01);
        check("dut4 ack", if4.o_Req_Ack, e.r ? 2'b10 : 2'b01);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && if0.o_TX_DV) begin
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut0 unexpected DV: got byte 0x%0h expected none", if0.o_TX_Byte);
      end else begin
        e = q0.pop_front();
        check("dut0 byte", if0.o_TX_Byte, e.b);
        check("dut0 grant", if0.o_Grant, e.r ? 2'b10 : 2'b01);
        check("dut0 ack", if0.o_Req_Ack, e.r ? 2'b10 : 2'b01);
      end
    end
  end

  // present one byte, hold until ack, release in the cycle after ack
  task automatic send(input bit z, input bit r, input logic [7:0] b, input logic last);
    bit got;
    got = 1'b0;
    if (z) begin z_b1 = b; z_l1 = last; z_v1 = 1'b1; end
    else if (r) begin a_b1 = b; a_l1 = last; a_v1 = 1'b1; end
    else begin a_b0 = b; a_l0 = last; a_v0 = 1'b1; end
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (z ? if0.o_Req_Ack[1] : if4.o_Req_Ack[r]) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("ack wait z%0d r%0d byte %02h", z, r, b), got, 1);
    @(posedge clk); #1;
    if (z) z_v1 = 1'b0;
    else if (r) a_v1 = 1'b0;
    else a_v0 = 1'b0;
  endtask

  task automatic wait_idle4(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!if4.o_Busy) begin got = 1'b1; break; end
    end
    check(name, got, 1);
    check({name, " queue drained"}, q4.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset state
    do_reset();
    check("rst grant", if4.o_Grant, 0);
    check("rst ack", if4.o_Req_Ack, 0);
    check("rst dv", if4.o_TX_DV, 0);
    check("rst byte", if4.o_TX_Byte, 0);
    check("rst busy", if4.o_Busy, 0);
    check("rst dut0 busy", if0.o_Busy, 0);
    check("rst dut0 grant", if0.o_Grant, 0);

    // 1: async reset in the middle of BUSY
    q4.push_back(mk(8'h5A, 1'b0));
    send(1'b0, 1'b0, 8'h5A, 1'b0);
    @(negedge clk);
    check("pre-reset busy", if4.o_Busy, 1);
    check("pre-reset grant", if4.o_Grant, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("async rst grant", if4.o_Grant, 0);
    check("async rst busy", if4.o_Busy, 0);
    check("async rst byte", if4.o_TX_Byte, 0);
    check("async rst dv", if4.o_TX_DV, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-reset idle", if4.o_Busy, 0);

    // 2: 3-byte burst from requester 0, grant held, 4-cycle gap after final ready
    q4.push_back(mk(8'h02, 1'b0));
    q4.push_back(mk(8'h05, 1'b0));
    q4.push_back(mk(8'h08, 1'b0));
    fork
      begin
        send(1'b0, 1'b0, 8'h02, 1'b0);
        send(1'b0, 1'b0, 8'h05, 1'b0);
        send(1'b0, 1'b0, 8'h08, 1'b1);
      end
      begin : watch
        int dvs, bad, n;
        bit got;
        dvs = 0; bad = 0; n = 0; got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
          @(negedge clk);
          if (dvs > 0 && if4.o_Grant != 2'b01) bad++;
          if (if4.o_TX_DV) dvs++;
          if (dvs == 3) break;
        end
        check("t2 dv count", dvs, 3);
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (if4.o_Grant != 2'b01) bad++;
          if (if4.i_TX_Ready) begin got = 1'b1; break; end
        end
        check("t2 final ready", got, 1);
        check("t2 grant held", bad, 0);
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (if4.o_Busy) n++;
          else break;
        end
        check("t2 gap cycles", n, 4);
        check("t2 grant released", if4.o_Grant, 0);
      end
    join
    check("t2 queue drained", q4.size(), 0);

    // 3: both valid together after reset; pointer favours requester 0
    do_reset();
    q4.push_back(mk(8'hA0, 1'b0));
    q4.push_back(mk(8'hA1, 1'b0));
    q4.push_back(mk(8'hB0, 1'b1));
    q4.push_back(mk(8'hB1, 1'b1));
    fork
      begin send(1'b0, 1'b0, 8'hA0, 1'b0); send(1'b0, 1'b0, 8'hA1, 1'b1); end
      begin send(1'b0, 1'b1, 8'hB0, 1'b0); send(1'b0, 1'b1, 8'hB1, 1'b1); end
    join
    wait_idle4("t3a idle");
    // single-byte burst from requester 0 moves the pointer to requester 1
    q4.push_back(mk(8'hC0, 1'b0));
    send(1'b0, 1'b0, 8'hC0, 1'b1);
    wait_idle4("t3 c0 idle");
    q4.push_back(mk(8'hB2, 1'b1));
    q4.push_back(mk(8'hB3, 1'b1));
    q4.push_back(mk(8'hA2, 1'b0));
    q4.push_back(mk(8'hA3, 1'b0));
    fork
      begin send(1'b0, 1'b0, 8'hA2, 1'b0); send(1'b0, 1'b0, 8'hA3, 1'b1); end
      begin send(1'b0, 1'b1, 8'hB2, 1'b0); send(1'b0, 1'b1, 8'hB3, 1'b1); end
    join
    wait_idle4("t3b idle");

    // 4: requester 0 stalls mid-burst while requester 1 waits
    q4.push_back(mk(8'h11, 1'b0));
    q4.push_back(mk(8'h12, 1'b0));
    q4.push_back(mk(8'h21, 1'b1));
    fork
      begin
        send(1'b0, 1'b0, 8'h11, 1'b0);
        for (int k = 0; k < 24; k++) begin
          @(negedge clk);
          check("t4 grant held", if4.o_Grant, 2'b01);
          check("t4 no dv", if4.o_TX_DV, 0);
        end
        send(1'b0, 1'b0, 8'h12, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        send(1'b0, 1'b1, 8'h21, 1'b1);
      end
    join
    wait_idle4("t4 idle");

    // 6: ready held low in IDLE blocks issue
    hold4 = 1'b1;
    q4.push_back(mk(8'h77, 1'b0));
    fork
      send(1'b0, 1'b0, 8'h77, 1'b1);
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("t6 no dv", if4.o_TX_DV, 0);
          check("t6 no ack", if4.o_Req_Ack, 0);
          check("t6 no grant", if4.o_Grant, 0);
        end
        hold4 = 1'b0;
        @(negedge clk);
        check("t6 dv after ready", if4.o_TX_DV, 1);
        check("t6 ack after ready", if4.o_Req_Ack, 2'b01);
      end
    join
    wait_idle4("t6 idle");

    // 5: no-gap instance, 8 single-byte bursts from requester 1
    for (int i = 0; i < 8; i++) q0.push_back(mk(8'(8'h30 + i), 1'b1));
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 8'(8'h30 + i), 1'b1);
      end
      begin : watch0
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (if0.o_TX_DV) begin got = 1'b1; break; end
        end
        check("t5 first dv", got, 1);
        for (int i = 0; i < 8; i++) begin
          got = 1'b0;
          for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if0.i_TX_Ready) begin got = 1'b1; break; end
          end
          check("t5 ready return", got, 1);
          @(negedge clk);
          check("t5 direct to idle", if0.o_Busy, 0);
          @(negedge clk);
          check("t5 next dv", if0.o_TX_DV, (i < 7) ? 1 : 0);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("t5 queue drained", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
